rr_encoder_arbiter: RTL and testbench

- Round-robin arbiter sharing one 4-to-2 encoded resource between four one-hot requesters Q0..Q3.
- Registers a one-hot grant plus its 2-bit encoded index (A = MSB, B = LSB), replacing the bare combinational encoder at the datapath front end.
- Guarantees that exactly one requester owns the resource at a time.
- Enforces fairness: the most recent owner has lowest priority on the next arbitration.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_priority_encoder.sv | 30 +++
 rtl/rr_encoder_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_encoder_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM state encoding for the round-robin encoder arbiter.
package arb_pkg;
  localparam int N            = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating-priority 4-to-2 encoder: first set request bit at or after ptr wins.
module rr_priority_encoder
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = '0;
    for (int i = 0; i < N; i++) begin
      // Modulo-4 wrap comes for free from the 2-bit index width.
      k = ptr + IDX_W'(i);
      if (!any && req[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = k;
      end
    end
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with registered one-hot grant and encoded index.
// Optional hold-time limit with timeout pulse when ARB_TIMEOUT_EN is defined.
module rr_encoder_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
`ifdef ARB_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic             grant_valid
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             release_c;

  logic [N-1:0]     enc_onehot;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  rr_priority_encoder u_enc (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (enc_onehot),
    .idx    (enc_idx),
    .any    (enc_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expire_c;

  assign expire_c = (cnt_q == CNT_W'(MAX_HOLD));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    release_c = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          grant_d = enc_onehot;
          idx_d   = enc_idx;
          valid_d = 1'b1;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        // done and an owner drop in the same cycle collapse into one release.
        release_c = done || !req[idx_q];
`ifdef ARB_TIMEOUT_EN
        if (!release_c && expire_c) begin
          release_c = 1'b1;
          timeout_d = 1'b1;
        end
        cnt_d = release_c ? '0 : cnt_q + CNT_W'(1);
`endif
        if (release_c) begin
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Scoreboard bench for rr_encoder_arbiter; covers the timeout path when ARB_TIMEOUT_EN is defined.
module tb_rr_encoder_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic       to;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  rr_encoder_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
`ifdef ARB_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
  task automatic cyc(input logic [3:0] r, input logic d, input logic [3:0] eg,
                     input logic [1:0] ei, input logic ev, input logic eto, input string nm);
    exp_t e;
    req  = r;
    done = d;
    e.g = eg; e.i = ei; e.v = ev; e.to = eto; e.nm = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.nm, ".grant"}, grant, mon_e.g);
      check({mon_e.nm, ".idx"}, {2'b00, grant_idx}, {2'b00, mon_e.i});
      check({mon_e.nm, ".valid"}, {3'b000, grant_valid}, {3'b000, mon_e.v});
`ifdef ARB_TIMEOUT_EN
      check({mon_e.nm, ".timeout"}, {3'b000, timeout}, {3'b000, mon_e.to});
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with all requesters active.
    repeat (3) @(negedge clk);
    check("rst.grant", grant, 4'b0000);
    check("rst.idx", {2'b00, grant_idx}, 4'h0);
    check("rst.valid", {3'b000, grant_valid}, 4'h0);
`ifdef ARB_TIMEOUT_EN
    check("rst.timeout", {3'b000, timeout}, 4'h0);
`endif
    rst = 1'b0;

    // First grant after reset goes to Q0, then rotate through all four.
    cyc(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "first");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_rel0");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap0");
    cyc(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_q1");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_rel1");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap1");
    cyc(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "rr_q2");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_rel2");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap2");
    cyc(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "rr_q3");
    cyc(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_rel3");
    cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap3");
    cyc(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_q0_again");

    // Owner drops its request: release, dead cycle, idle with no request.
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_rel");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_dead");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_noreq");

    // Single requester Q2 (ptr=1), non-owner changes ignored while held.
    cyc(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "single_q2");
    cyc(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "single_hold");
    cyc(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "nonowner_chg");
    // done and owner drop together: one release; done ignored in RELEASE/IDLE.
    cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "dual_rel");
    cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "done_in_rel");
    cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "done_in_idle");

    // Wrap-around: ptr=3 after Q2, req 0101 -> Q0.
    cyc(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "wrap_q0");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap_rel");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "wrap_dead");

    // Grant Q3 (ptr=1), then async reset in the middle of the grant.
    cyc(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "pre_rst_q3");
    cyc(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "pre_rst_hold");
    #2;
    rst = 1'b1;
    req = 4'b1111;
    #1;
    check("async_rst.grant", grant, 4'b0000);
    check("async_rst.idx", {2'b00, grant_idx}, 4'h0);
    check("async_rst.valid", {3'b000, grant_valid}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "post_rst_q0");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "post_rst_rel");
    cyc(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "post_rst_dead");

    // Q1 holds its request with done low (ptr=1).
    cyc(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "hold_q1");
    for (int k = 0; k < 7; k++)
      cyc(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "hold_q1_n");
`ifdef ARB_TIMEOUT_EN
    cyc(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "to_force");
    cyc(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "to_dead");
    cyc(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "to_regrant");
`else
    for (int k = 0; k < 4; k++)
      cyc(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "hold_long");
    cyc(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "hold_done");
`endif

    // Let the monitor drain, with a bound.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
